// File: rtl/sram_scan_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_scan_if : scan pins, SRAM macro bus and status flags of sram_scan_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
interface sram_scan_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11,
   parameter int ERR_W  = 8
);
   logic              scan_en;
   logic              scan_in;
   logic              scan_out;
   logic              scan_out_valid;
   logic              sram_ce;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [ERR_W-1:0]  err_cnt;

   // master: the scan controller; slave: scan pins plus the SRAM macro
   modport master (
      input  scan_en, scan_in, sram_rdata,
      output scan_out, scan_out_valid, sram_ce, sram_we, sram_addr, sram_wdata,
      output busy, done, err, err_cnt
   );

   modport slave (
      output scan_en, scan_in, sram_rdata,
      input  scan_out, scan_out_valid, sram_ce, sram_we, sram_addr, sram_wdata,
      input  busy, done, err, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/sram_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_scan_ctrl : bit-serial scan frame controller for a single-port SRAM.
// Readback-verify mode is built only when SRAM_SCAN_VERIFY_EN is defined.
// Rev 1.0
// ----------------------------------------------------------------------------
module sram_scan_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 11,
   parameter int ERR_W  = 8
) (
   input  wire logic   clk,
   input  wire logic   rst,
   sram_scan_if.master bus
);
   localparam int c_hdr_bits = 2 + CNT_W + ADDR_W;
   localparam int c_max_bits = (c_hdr_bits > DATA_W) ? c_hdr_bits : DATA_W;
   localparam int c_bw       = $clog2(c_max_bits);

   localparam logic [2:0] c_st_hdr      = 3'd0;
   localparam logic [2:0] c_st_wr_shift = 3'd1;
   localparam logic [2:0] c_st_rd_req   = 3'd2;
   localparam logic [2:0] c_st_rd_wait  = 3'd3;
   localparam logic [2:0] c_st_rd_shift = 3'd4;
`ifdef SRAM_SCAN_VERIFY_EN
   localparam logic [2:0] c_st_vf_shift = 3'd5;
   localparam logic [2:0] c_st_vf_cmp   = 3'd6;
`endif
   localparam logic [2:0] c_st_done     = 3'd7;

   logic [2:0]            r_state;
   logic [2:0]            w_state_nx;
   logic [c_bw-1:0]       r_bit;
   logic [c_hdr_bits-2:0] r_hdr;
   logic [DATA_W-1:0]     r_sreg;
   logic [DATA_W-1:0]     r_wdata;
   logic [ADDR_W-1:0]     r_addr;
   logic [CNT_W:0]        r_remain;
   logic                  r_wr_pend;

   logic                  w_shift;
   logic                  w_bit_last;
   logic                  w_last_word;
   logic                  w_collect;
   logic                  w_vf_state;
   logic                  w_vf_rd;
   logic                  w_vf_chk;
   logic                  w_ce;
   logic [c_hdr_bits-1:0] w_hdr_word;
   logic [1:0]            w_opc;
   logic [CNT_W-1:0]      w_hdr_cnt;
   logic [ADDR_W-1:0]     w_hdr_addr;
   logic [DATA_W-1:0]     w_data_word;

   assign w_hdr_word  = {bus.scan_in, r_hdr};
   assign w_opc       = w_hdr_word[1:0];
   assign w_hdr_cnt   = w_hdr_word[2 +: CNT_W];
   assign w_hdr_addr  = w_hdr_word[2 + CNT_W +: ADDR_W];
   assign w_data_word = {bus.scan_in, r_sreg[DATA_W-1:1]};

   assign w_collect   = (r_state == c_st_wr_shift) || w_vf_state;
   assign w_shift     = bus.scan_en && ((r_state == c_st_hdr) || w_collect ||
                                        (r_state == c_st_rd_shift));
   assign w_bit_last  = (r_state == c_st_hdr) ? (r_bit == c_bw'(c_hdr_bits - 1))
                                              : (r_bit == c_bw'(DATA_W - 1));
   assign w_last_word = (r_remain == (CNT_W + 1)'(1));
   assign w_ce        = r_wr_pend || (r_state == c_st_rd_req) || w_vf_rd;

   always_ff @(posedge clk) begin
      if (rst) r_state <= c_st_hdr;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         c_st_hdr: begin
            if (w_shift && w_bit_last) begin
               case (w_opc)
                  2'b01:   w_state_nx = c_st_wr_shift;
                  2'b10:   w_state_nx = c_st_rd_req;
`ifdef SRAM_SCAN_VERIFY_EN
                  2'b11:   w_state_nx = c_st_vf_shift;
`endif
                  default: w_state_nx = c_st_done;
               endcase
            end
         end
         c_st_wr_shift: if (w_shift && w_bit_last && w_last_word) w_state_nx = c_st_done;
         c_st_rd_req:   w_state_nx = c_st_rd_wait;
         c_st_rd_wait:  w_state_nx = c_st_rd_shift;
         c_st_rd_shift: begin
            if (w_shift && w_bit_last) w_state_nx = w_last_word ? c_st_done : c_st_rd_req;
         end
`ifdef SRAM_SCAN_VERIFY_EN
         c_st_vf_shift: if (w_shift && w_bit_last && w_last_word) w_state_nx = c_st_vf_cmp;
         // the last word's read is still in flight; finish on its compare edge
         c_st_vf_cmp:   if (w_vf_chk && !w_vf_rd) w_state_nx = c_st_done;
`endif
         default:       w_state_nx = r_state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit     <= '0;
         r_hdr     <= '0;
         r_sreg    <= '0;
         r_wdata   <= '0;
         r_addr    <= '0;
         r_remain  <= '0;
         r_wr_pend <= 1'b0;
      end else begin
         r_wr_pend <= 1'b0;
         if (w_shift) r_bit <= w_bit_last ? '0 : r_bit + c_bw'(1);
         if (w_ce) r_addr <= r_addr + ADDR_W'(1);
         if ((r_state == c_st_hdr) && w_shift) begin
            r_hdr <= w_hdr_word[c_hdr_bits-1:1];
            if (w_bit_last) begin
               r_addr   <= w_hdr_addr;
               r_remain <= {1'b0, w_hdr_cnt} + (CNT_W + 1)'(1);
            end
         end
         if (w_collect && w_shift) begin
            r_sreg <= w_data_word;
            if (w_bit_last) begin
               r_remain <= r_remain - (CNT_W + 1)'(1);
               if (r_state == c_st_wr_shift) begin
                  r_wdata   <= w_data_word;
                  r_wr_pend <= 1'b1;
               end
            end
         end
         if (r_state == c_st_rd_wait) r_sreg <= bus.sram_rdata;
         if ((r_state == c_st_rd_shift) && w_shift) begin
            r_sreg <= r_sreg >> 1;
            if (w_bit_last) r_remain <= r_remain - (CNT_W + 1)'(1);
         end
      end
   end

`ifdef SRAM_SCAN_VERIFY_EN
   logic              r_vf_rd;
   logic              r_vf_chk;
   logic              r_err;
   logic [ERR_W-1:0]  r_err_cnt;
   logic [DATA_W-1:0] r_cmp;

   assign w_vf_state = (r_state == c_st_vf_shift);
   assign w_vf_rd    = r_vf_rd;
   assign w_vf_chk   = r_vf_chk;

   // read strobe one cycle after the word completes, compare when rdata returns
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vf_rd   <= 1'b0;
         r_vf_chk  <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
         r_cmp     <= '0;
      end else begin
         r_vf_rd  <= 1'b0;
         r_vf_chk <= r_vf_rd;
         if (w_vf_state && w_shift && w_bit_last) begin
            r_vf_rd <= 1'b1;
            r_cmp   <= w_data_word;
         end
         if (r_vf_chk && (bus.sram_rdata != r_cmp)) begin
            r_err <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
         end
      end
   end
`else
   assign w_vf_state = 1'b0;
   assign w_vf_rd    = 1'b0;
   assign w_vf_chk   = 1'b0;
`endif

   always_comb begin
      bus.busy           = (r_state != c_st_hdr) && (r_state != c_st_done);
      bus.done           = (r_state == c_st_done);
      bus.scan_out_valid = (r_state == c_st_rd_shift);
      bus.scan_out       = (r_state == c_st_rd_shift) && r_sreg[0];
      bus.sram_ce        = w_ce;
      bus.sram_we        = r_wr_pend;
      bus.sram_addr      = r_addr;
      bus.sram_wdata     = r_wdata;
`ifdef SRAM_SCAN_VERIFY_EN
      bus.err            = r_err;
      bus.err_cnt        = r_err_cnt;
`else
      bus.err            = 1'b0;
      bus.err_cnt        = ERR_W'(0);
`endif
   end
endmodule
`default_nettype wire

// File: tb/tb_sram_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sram_scan_ctrl : scoreboard bench with an SRAM model and a memory-array
// reference model. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_scan_ctrl;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 11;
   localparam int CNT_W    = 11;
   localparam int ERR_W    = 8;
   localparam int HDR_BITS = 2 + CNT_W + ADDR_W;
   localparam int DEPTH    = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_scan_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ERR_W(ERR_W)) bus ();

   sram_scan_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DATA_W-1:0] sram_mem [DEPTH];
   logic [DATA_W-1:0] ref_mem  [DEPTH];

   always @(posedge clk) begin
      if (bus.sram_ce) begin
         if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wdata;
         else             bus.sram_rdata <= sram_mem[bus.sram_addr];
      end
   end

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t               wq[$];
   logic [DATA_W-1:0] rq[$];
   logic [DATA_W-1:0] words[$];
   wr_t               mon_wr;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] exp_word;
   int                acc_n = 0;
   int                rd_strobes = 0;
   int                checks = 0;
   int                errors = 0;
   int                en_mode = 0;
   bit                tog = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: pops expectations whenever the DUT presents a write or a full read word
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.sram_ce && bus.sram_we) begin
            if (wq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                        bus.sram_addr, bus.sram_wdata);
            end else begin
               mon_wr = wq.pop_front();
               check("wr_addr", bus.sram_addr, mon_wr.addr);
               check("wr_data", bus.sram_wdata, mon_wr.data);
            end
         end
         if (bus.sram_ce && !bus.sram_we) rd_strobes++;
         if (bus.scan_out_valid) begin
            if (bus.scan_en) begin
               acc = {bus.scan_out, acc[DATA_W-1:1]};
               acc_n++;
               if (acc_n == DATA_W) begin
                  acc_n = 0;
                  if (rq.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_read_word: got %0h, expected none", acc);
                  end else begin
                     exp_word = rq.pop_front();
                     check("rd_word", acc, exp_word);
                  end
               end
            end
         end else begin
            check("scan_out_idle", bus.scan_out, 0);
         end
      end
   end

   function automatic bit next_en();
      if (en_mode == 0) return 1'b1;
      if (en_mode == 1) begin
         tog = ~tog;
         return tog;
      end
      return 1'($urandom);
   endfunction

   task automatic idle();
      bus.scan_en = next_en();
      bus.scan_in = 1'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bit(input bit b);
      bit en;
      int tries = 0;
      do begin
         en = next_en();
         if (tries >= 8) en = 1'b1;
         bus.scan_en = en;
         bus.scan_in = en ? b : 1'($urandom);
         tries++;
         @(posedge clk);
         #1;
      end while (!en);
   endtask

   task automatic send_header(input logic [1:0] opc, input logic [CNT_W-1:0] cnt,
                              input logic [ADDR_W-1:0] addr);
      logic [HDR_BITS-1:0] hdr;
      hdr = {addr, cnt, opc};
      for (int i = 0; i < HDR_BITS; i++) shift_bit(hdr[i]);
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w);
      for (int b = 0; b < DATA_W; b++) shift_bit(w[b]);
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (!bus.done && n < limit) begin
         idle();
         n++;
      end
      idle();
      idle();
      check("done", bus.done, 1);
      check("busy", bus.busy, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.scan_en = 1'b0;
      bus.scan_in = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      acc_n = 0;
      rd_strobes = 0;
      tog = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ce"}, bus.sram_ce, 0);
      check({tag, "_we"}, bus.sram_we, 0);
      check({tag, "_addr"}, bus.sram_addr, 0);
      check({tag, "_wdata"}, bus.sram_wdata, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_scan_out"}, {bus.scan_out, bus.scan_out_valid}, 0);
      check({tag, "_err"}, {bus.err, bus.err_cnt}, 0);
   endtask

   task automatic write_frame(input logic [CNT_W-1:0] cnt, input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] a;
      wr_t e;
      do_reset();
      send_header(2'b01, cnt, addr);
      check("wr_busy", bus.busy, 1);
      for (int i = 0; i <= int'(cnt); i++) begin
         a = ADDR_W'(int'(addr) + i);
         e.addr = a;
         e.data = words[i];
         wq.push_back(e);
         ref_mem[a] = words[i];
         send_word(words[i]);
      end
      wait_done(20);
      check("wr_pending", wq.size(), 0);
   endtask

   task automatic read_frame(input logic [CNT_W-1:0] cnt, input logic [ADDR_W-1:0] addr);
      int n = 0;
      do_reset();
      for (int i = 0; i <= int'(cnt); i++) rq.push_back(ref_mem[ADDR_W'(int'(addr) + i)]);
      send_header(2'b10, cnt, addr);
      while (!bus.scan_out_valid && n < 10) begin
         idle();
         n++;
      end
      check("rd_latency", n, 2);
      wait_done((int'(cnt) + 1) * DATA_W * 9 + 50);
      check("rd_pending", rq.size(), 0);
      check("rd_strobes", rd_strobes, int'(cnt) + 1);
   endtask

   task automatic verify_frame(input logic [CNT_W-1:0] cnt, input logic [ADDR_W-1:0] addr);
      int exp_err = 0;
      do_reset();
      for (int i = 0; i <= int'(cnt); i++)
         if (words[i] != ref_mem[ADDR_W'(int'(addr) + i)]) exp_err++;
      send_header(2'b11, cnt, addr);
      for (int i = 0; i <= int'(cnt); i++) send_word(words[i]);
      wait_done(20);
`ifdef SRAM_SCAN_VERIFY_EN
      check("vf_err", bus.err, exp_err != 0);
      check("vf_err_cnt", bus.err_cnt, (exp_err > 255) ? 255 : exp_err);
      check("vf_rd_strobes", rd_strobes, int'(cnt) + 1);
`else
      check("vf_off_err", {bus.err, bus.err_cnt}, 0);
      check("vf_off_rd_strobes", rd_strobes, 0);
`endif
   endtask

   initial begin
      logic [DATA_W-1:0] v;
      logic [DATA_W-1:0] fixed_words[4];
      int op;
      fixed_words = '{32'h00012117, 32'h04010113, 32'h00022517, 32'h03c50513};
      for (int i = 0; i < DEPTH; i++) begin
         v = (i * 32'h9E3779B1) ^ 32'h5A5A1234;
         sram_mem[i] <= v;
         ref_mem[i]  = v;
      end
      bus.sram_rdata = '0;

      do_reset();
      check_outputs_zero("reset");

      en_mode = 0;
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back(fixed_words[i]);
      write_frame(11'd3, 11'd0);
      read_frame(11'd3, 11'd0);

      words.delete();
      words.push_back($urandom);
      words.push_back($urandom);
      write_frame(11'd1, 11'h7FF);
      read_frame(11'd1, 11'h7FF);

      words.delete();
      for (int i = 0; i < 4; i++) words.push_back(fixed_words[i]);
      words[2] = words[2] ^ 32'h0000_0100;
      verify_frame(11'd3, 11'd0);

      do_reset();
      send_header(2'b00, 11'd5, 11'd9);
      wait_done(4);
      check("nop_rd_strobes", rd_strobes, 0);

      en_mode = 1;
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back(32'hFFFF_FFFF ^ fixed_words[i]);
      write_frame(11'd3, 11'd0);
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back(fixed_words[i]);
      write_frame(11'd3, 11'd0);

      // abort: reset lands during bit 17 of the second word
      en_mode = 0;
      do_reset();
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back($urandom);
      mon_wr.addr = 11'h010;
      mon_wr.data = words[0];
      wq.push_back(mon_wr);
      ref_mem[11'h010] = words[0];
      send_header(2'b01, 11'd3, 11'h010);
      send_word(words[0]);
      for (int b = 0; b < 17; b++) shift_bit(words[1][b]);
      bus.scan_en = 1'b1;
      bus.scan_in = words[1][17];
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.scan_en = 1'b0;
      check_outputs_zero("abort");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
      end
      check("abort_pending", wq.size(), 0);
      read_frame(11'd1, 11'h010);

      for (int k = 0; k < 8; k++) begin
         logic [CNT_W-1:0]  cnt;
         logic [ADDR_W-1:0] addr;
         op      = $urandom_range(0, 2);
         cnt     = CNT_W'($urandom_range(0, 3));
         addr    = ($urandom_range(0, 3) == 0) ? ADDR_W'(DEPTH - 2) : ADDR_W'($urandom);
         en_mode = $urandom_range(0, 2);
         words.delete();
         for (int i = 0; i <= int'(cnt); i++) begin
            v = ref_mem[ADDR_W'(int'(addr) + i)];
            if (op != 2 || $urandom_range(0, 1) == 1) v = $urandom;
            words.push_back(v);
         end
         case (op)
            0:       write_frame(cnt, addr);
            1:       read_frame(cnt, addr);
            default: verify_frame(cnt, addr);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sram_scan_ctrl.md
Name: sram_scan_ctrl

Overview:
- Parametrised serial scan controller for an external single-port synchronous SRAM; the successor to the fixed 32-bit scan wrapper.
- A bit-serial frame (opcode, word count, start address, data) moves data through scan_in/scan_out, LSB first.
- Adds configurable data, address and count widths, scan_en gating, a scan_out_valid qualifier, status flags and a readback-verify mode.
- Sits between the chip-level scan pins and the instruction/data SRAM macro.

Parameters:
- DATA_W, 32, SRAM word width and data field length in bits
- ADDR_W, 11, SRAM address width; memory depth is 2^ADDR_W
- CNT_W, 11, count field width; words transferred = count+1
- ERR_W, 8, width of the saturating mismatch counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- scan_en  in  1  a scan bit is consumed/produced only on clk edges with scan_en=1
- scan_in  in  1  serial input, LSB first
- scan_out  out  1  serial read data, LSB first
- scan_out_valid  out  1  scan_out carries a data bit this cycle
- sram_ce  out  1  SRAM access strobe, one cycle per access
- sram_we  out  1  write when sram_ce=1
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read strobe
- busy  out  1  frame in progress (header received, not yet done)
- done  out  1  frame complete; sticky until rst
- err  out  1  sticky verify mismatch flag
- err_cnt  out  ERR_W  number of mismatched words, saturating

Behaviour:
- Reset (rst=1 at an edge): all outputs 0, FSM in HDR, bit counters and shift registers cleared. Reset mid-frame aborts the frame; any SRAM strobe scheduled for the following cycle is suppressed.
- Header: HDR_BITS = 2+CNT_W+ADDR_W bits shifted in on enabled edges.
  - opcode[1:0] arrives first: 00 NOP, 01 WRITE, 10 READ, 11 VERIFY.
  - Then count, then start address.
  - busy rises the cycle after the last header bit is sampled.
- FSM states: HDR, WR_SHIFT, RD_REQ, RD_WAIT, RD_SHIFT, VF_SHIFT, VF_CMP, DONE.
- NOP: HDR -> DONE directly. busy stays 0; done=1.
- WRITE (HDR -> WR_SHIFT): collect DATA_W bits per word.
  - On the edge that samples the final bit, the word is copied to sram_wdata.
  - Next cycle: sram_ce=sram_we=1 at the current address. Shifting of the next word continues during that cycle.
  - Address increments modulo 2^ADDR_W after each write.
  - After count+1 writes -> DONE.
- READ (HDR -> RD_REQ):
  - RD_REQ: sram_ce=1, sram_we=0 for one cycle.
  - RD_WAIT: sram_rdata captured into the output shift register at the end of this cycle.
  - RD_SHIFT: scan_out=sreg[0] and scan_out_valid=1. Each enabled edge shifts right.
  - After DATA_W shifts, go to RD_REQ for the next address, or DONE after count+1 words.
  - The 2-cycle gap between words has scan_out=0 and scan_out_valid=0.
- VERIFY (HDR -> VF_SHIFT): collect a word exactly as in WRITE.
  - Then issue a read instead of a write; VF_CMP compares sram_rdata to the collected word.
  - On mismatch: err<=1 and err_cnt increments, saturating at all-ones.
  - Shifting of the next word is not blocked.
- Address and count arithmetic: address wraps at 2^ADDR_W. Count all-ones transfers 2^CNT_W words; the internal remaining counter is CNT_W+1 bits.
- scan_en=0: the shift/bit counters hold. SRAM strobes already scheduled still complete on the next cycle.
- DONE: busy=0, done=1, scan_out=0, scan_out_valid=0. Further scan_in is ignored until rst.
- Latency: from the last header bit of a READ to the first valid scan_out bit is exactly 2 cycles.

Optional Feature:
- Macro SRAM_SCAN_VERIFY_EN.
- Defined: VERIFY mode, err and err_cnt logic are present.
- Undefined: opcode 11 behaves as NOP (straight to DONE, no SRAM access); err and err_cnt are tied to 0.

Test Plan:
- Reset, WRITE with count=3, addr=0, words 00012117, 04010113, 00022517, 03c50513, scan_en=1 -> four sram_ce/we pulses at addr 0..3 with matching sram_wdata; done=1, busy=0.
- READ with count=3, addr=0 against a model preloaded by the previous test -> scan_out streams the same four words LSB first, 32 valid bits each with 2-cycle gaps; first valid bit 2 cycles after the header.
- WRITE with count=1, addr=0x7FF (ADDR_W=11) -> writes land at 0x7FF then 0x000 (wrap).
- VERIFY (macro defined) of 4 words where word 2 differs -> err=1, err_cnt=1, no sram_we. Without the macro: opcode 11 gives done=1 and no sram_ce.
- Toggle scan_en 1/0 every cycle during WRITE -> same SRAM writes as the first test, at double the duration.
- Assert rst during bit 17 of the second WRITE word -> no second write pulse, all outputs 0. A new frame after reset works normally.
